time_set_ctrl: RTL and testbench

Front-panel controller that sits directly upstream of the hours/minutes/seconds `counter` chain and drives their `set_value` / `value_to_set` inputs. It debounces two push buttons (MODE, UP) and walks through a field-selection state machine. While a field is selected it increments a working copy of that field with wrap-around and loads it into the matching counter. It also gates the seconds tick (`run_en`) so time is frozen while editing.

---
 rtl/timeset_pkg.sv | 17 +
 rtl/btn_debounce.sv | 52 +++++
 rtl/time_set_ctrl.sv | 117 +++++++++++
 tb/tb_time_set_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timeset_pkg.sv
// Shared encodings for the front-panel time-setting controller.
// The FSM state code doubles as the edit_field output code.
package timeset_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_EDIT_HOUR = 2'd1,
        ST_EDIT_MIN  = 2'd2,
        ST_EDIT_SEC  = 2'd3
    } state_t;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and
// rising-edge detector producing a single-cycle press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] stable_cnt;
    logic             level_q;
    logic             level_d1;
    logic             press_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0    <= 1'b0;
            sync_p1    <= 1'b0;
            stable_cnt <= '0;
            level_q    <= 1'b0;
            level_d1   <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            sync_p0  <= btn_raw;
            sync_p1  <= sync_p0;
            level_d1 <= level_q;
            press_q  <= level_q & ~level_d1;
            // Any sample matching the accepted level restarts the stability count.
            if (sync_p1 != level_q) begin
                if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_q    <= sync_p1;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel controller: MODE walks RUN->HOUR->MIN->SEC->RUN, UP increments
// the selected field with wrap and loads it into the matching counter.
module time_set_ctrl
    import timeset_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOUR_MAX        = 23,
    parameter int MIN_MAX         = 59,
    parameter int SEC_MAX         = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_mode,
    input  logic             btn_up,
    input  logic [WIDTH-1:0] cur_hour,
    input  logic [WIDTH-1:0] cur_min,
    input  logic [WIDTH-1:0] cur_sec,
    output logic [WIDTH-1:0] value_to_set,
    output logic             set_hour,
    output logic             set_min,
    output logic             set_sec,
    output logic             run_en,
    output logic [1:0]       edit_field
);

    function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v,
                                                  input logic [WIDTH-1:0] max);
        return (v == max) ? '0 : v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] field_max(input state_t st);
        case (st)
            ST_EDIT_HOUR: return WIDTH'(HOUR_MAX);
            ST_EDIT_MIN:  return WIDTH'(MIN_MAX);
            default:      return WIDTH'(SEC_MAX);
        endcase
    endfunction

    logic mode_level, mode_press, up_level, up_press;
    logic mode_hit, up_hit;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .rst(rst), .btn_raw(btn_mode), .level(mode_level), .press(mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .rst(rst), .btn_raw(btn_up), .level(up_level), .press(up_press)
    );

    state_t           state_q, state_d;
    logic [WIDTH-1:0] working_q, working_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [1:0]       pend_field_p1, pend_field_d;
    logic             set_hour_p2, set_min_p2, set_sec_p2;

    // A press pulse is always accompanied by its accepted level; MODE has priority.
    assign mode_hit = mode_press & mode_level;
    assign up_hit   = up_press & up_level & ~mode_hit & (state_q != ST_RUN);

    always_comb begin
        state_d      = state_q;
        working_d    = working_q;
        value_d      = value_q;
        pend_field_d = FIELD_NONE;
        if (mode_hit) begin
            case (state_q)
                ST_RUN: begin
                    state_d   = ST_EDIT_HOUR;
                    working_d = cur_hour;
                end
                ST_EDIT_HOUR: begin
                    state_d   = ST_EDIT_MIN;
                    working_d = cur_min;
                end
                ST_EDIT_MIN: begin
                    state_d   = ST_EDIT_SEC;
                    working_d = cur_sec;
                end
                default: state_d = ST_RUN;
            endcase
        end else if (up_hit) begin
            working_d    = wrap_inc(working_q, field_max(state_q));
            value_d      = working_d;
            pend_field_d = state_q;
        end
    end

    // Stage p1: remember the field owning the load; stage p2: the load strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            working_q     <= '0;
            value_q       <= '0;
            pend_field_p1 <= FIELD_NONE;
            set_hour_p2   <= 1'b0;
            set_min_p2    <= 1'b0;
            set_sec_p2    <= 1'b0;
        end else begin
            state_q       <= state_d;
            working_q     <= working_d;
            value_q       <= value_d;
            pend_field_p1 <= pend_field_d;
            set_hour_p2   <= (pend_field_p1 == FIELD_HOUR);
            set_min_p2    <= (pend_field_p1 == FIELD_MIN);
            set_sec_p2    <= (pend_field_p1 == FIELD_SEC);
        end
    end

    assign value_to_set = value_q;
    assign set_hour     = set_hour_p2;
    assign set_min      = set_min_p2;
    assign set_sec      = set_sec_p2;
    assign run_en       = (state_q == ST_RUN);
    assign edit_field   = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: table of single-increment vectors plus
// hand-written sequences for multi-cycle corner cases.
module tb_time_set_ctrl;

    localparam int DC  = 16;
    localparam int LAT = DC + 5;   // raw button edge to set_* visible

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic [7:0] cur_hour = '0;
    logic [7:0] cur_min = '0;
    logic [7:0] cur_sec = '0;
    logic [7:0] value_to_set;
    logic       set_hour, set_min, set_sec, run_en;
    logic [1:0] edit_field;

    time_set_ctrl #(.WIDTH(8), .DEBOUNCE_CYCLES(DC), .HOUR_MAX(23), .MIN_MAX(59), .SEC_MAX(59)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .value_to_set(value_to_set), .set_hour(set_hour), .set_min(set_min),
        .set_sec(set_sec), .run_en(run_en), .edit_field(edit_field)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_hour = 0, n_min = 0, n_sec = 0;
    int last_val = -1, last_cyc = -1;
    int s_hour, s_min, s_sec;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (set_hour || set_min || set_sec) begin
            check("set_onehot", int'(set_hour) + int'(set_min) + int'(set_sec), 1);
            last_val = int'(value_to_set);
            last_cyc = cyc;
            if (set_hour) n_hour++;
            if (set_min)  n_min++;
            if (set_sec)  n_sec++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic press(input bit is_mode, output int drive_cyc);
        if (is_mode) btn_mode = 1'b1; else btn_up = 1'b1;
        drive_cyc = cyc;
        tick(DC + 8);
        if (is_mode) btn_mode = 1'b0; else btn_up = 1'b0;
        tick(DC + 6);
    endtask

    task automatic snap();
        s_hour = n_hour;
        s_min  = n_min;
        s_sec  = n_sec;
    endtask

    typedef struct {
        int         field;
        logic [7:0] cur;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d, d2;

        vecs[0] = '{1, 8'd22,  8'd23};
        vecs[1] = '{1, 8'd23,  8'd0};
        vecs[2] = '{2, 8'd59,  8'd0};
        vecs[3] = '{2, 8'd0,   8'd1};
        vecs[4] = '{3, 8'd59,  8'd0};
        vecs[5] = '{3, 8'd58,  8'd59};
        vecs[6] = '{1, 8'd200, 8'd201};
        vecs[7] = '{2, 8'd255, 8'd0};

        // Reset then idle
        do_reset();
        tick(100);
        check("rst_run_en", int'(run_en), 1);
        check("rst_edit_field", int'(edit_field), 0);
        check("rst_sets", int'(set_hour) + int'(set_min) + int'(set_sec), 0);
        check("rst_value", int'(value_to_set), 0);
        check("rst_no_pulse", n_hour + n_min + n_sec, 0);

        // Table: enter a field, one UP press, check the load
        for (int i = 0; i < 8; i++) begin
            do_reset();
            cur_hour = 8'd0; cur_min = 8'd0; cur_sec = 8'd0;
            case (vecs[i].field)
                1: cur_hour = vecs[i].cur;
                2: cur_min  = vecs[i].cur;
                default: cur_sec = vecs[i].cur;
            endcase
            snap();
            for (int m = 1; m <= vecs[i].field; m++) begin
                press(1'b1, d);
                check("vec_edit_field", int'(edit_field), m);
            end
            check("vec_run_en", int'(run_en), 0);
            check("vec_no_entry_load", (n_hour + n_min + n_sec) - (s_hour + s_min + s_sec), 0);
            snap();
            press(1'b0, d);
            check("vec_hour_cnt", n_hour - s_hour, vecs[i].field == 1 ? 1 : 0);
            check("vec_min_cnt", n_min - s_min, vecs[i].field == 2 ? 1 : 0);
            check("vec_sec_cnt", n_sec - s_sec, vecs[i].field == 3 ? 1 : 0);
            check("vec_load_val", last_val, int'(vecs[i].exp));
            check("vec_latency", last_cyc - d, LAT);
            check("vec_value_held", int'(value_to_set), int'(vecs[i].exp));
        end

        // Hour 22, two UP presses: 23 then 0
        do_reset();
        cur_hour = 8'd22;
        press(1'b1, d);
        snap();
        press(1'b0, d);
        check("h2_val1", last_val, 23);
        check("h2_lat1", last_cyc - d, LAT);
        press(1'b0, d2);
        check("h2_val2", last_val, 0);
        check("h2_lat2", last_cyc - d2, LAT);
        check("h2_count", n_hour - s_hour, 2);

        // Bouncing UP then held: a single increment
        do_reset();
        cur_hour = 8'd10;
        press(1'b1, d);
        snap();
        for (int i = 0; i < 40; i++) begin
            btn_up = (((i / 3) % 2) == 0);
            tick(1);
        end
        check("bounce_no_load", n_hour - s_hour, 0);
        btn_up = 1'b1;
        d = cyc;
        tick(DC + 8);
        btn_up = 1'b0;
        tick(DC + 6);
        check("bounce_count", n_hour - s_hour, 1);
        check("bounce_val", last_val, 11);
        check("bounce_lat", last_cyc - d, LAT);

        // MODE x3, UP at sec 59, fourth MODE back to RUN
        do_reset();
        cur_hour = 8'd3; cur_min = 8'd4; cur_sec = 8'd59;
        for (int m = 0; m < 3; m++) press(1'b1, d);
        check("sec_field", int'(edit_field), 3);
        snap();
        press(1'b0, d);
        check("sec_count", n_sec - s_sec, 1);
        check("sec_val", last_val, 0);
        snap();
        press(1'b1, d);
        check("sec_exit_run_en", int'(run_en), 1);
        check("sec_exit_field", int'(edit_field), 0);
        check("sec_exit_no_load", (n_hour + n_min + n_sec) - (s_hour + s_min + s_sec), 0);

        // MODE and UP together in EDIT_MIN
        do_reset();
        cur_min = 8'd30;
        press(1'b1, d);
        press(1'b1, d);
        check("both_pre_field", int'(edit_field), 2);
        snap();
        btn_mode = 1'b1;
        btn_up = 1'b1;
        tick(DC + 8);
        btn_mode = 1'b0;
        btn_up = 1'b0;
        tick(DC + 6);
        check("both_field", int'(edit_field), 3);
        check("both_no_load", (n_hour + n_min + n_sec) - (s_hour + s_min + s_sec), 0);

        // Reset between UP press pulse and its load
        do_reset();
        cur_hour = 8'd5;
        press(1'b1, d);
        snap();
        btn_up = 1'b1;
        tick(DC + 4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rstmid_field", int'(edit_field), 0);
        check("rstmid_run_en", int'(run_en), 1);
        check("rstmid_value", int'(value_to_set), 0);
        tick(DC + 8);
        btn_up = 1'b0;
        tick(DC + 6);
        check("rstmid_no_load", (n_hour + n_min + n_sec) - (s_hour + s_min + s_sec), 0);
        check("rstmid_value_after", int'(value_to_set), 0);

        // MODE held through reset release: one fresh press
        btn_mode = 1'b1;
        tick(DC + 8);
        check("hold_pre_field", int'(edit_field), 1);
        do_reset();
        check("hold_rst_field", int'(edit_field), 0);
        tick(DC + 8);
        check("hold_one_press", int'(edit_field), 1);
        tick(DC + 8);
        check("hold_still_one", int'(edit_field), 1);
        btn_mode = 1'b0;
        tick(DC + 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
